// File: rtl/ps2_turn_scheduler_if.sv
// ps2_turn_scheduler_if: key-event and game-step bundle between PS/2 decoder, game logic and turn scheduler
//   valid/makeBreak/outCode : key event strobe, make(1)/break(0), set-2 scan code
//   tick/start              : game-step strobe, synchronous re-initialise strobe
//   dir_p1/dir_p2           : committed directions (0 up, 1 right, 2 down, 3 left)
//   turn_p1/turn_p2/step    : per-step strobes
//   paused/qcnt_p1/qcnt_p2  : pause state and queue occupancy
//   drop                    : a legal-key make was discarded
interface ps2_turn_scheduler_if;
    logic       valid;
    logic       makeBreak;
    logic [7:0] outCode;
    logic       tick;
    logic       start;
    logic [1:0] dir_p1;
    logic [1:0] dir_p2;
    logic       turn_p1;
    logic       turn_p2;
    logic       step;
    logic       paused;
    logic [2:0] qcnt_p1;
    logic [2:0] qcnt_p2;
    logic       drop;
    modport master (
        output valid, makeBreak, outCode, tick, start,
        input  dir_p1, dir_p2, turn_p1, turn_p2, step, paused, qcnt_p1, qcnt_p2, drop
    );
    modport slave (
        input  valid, makeBreak, outCode, tick, start,
        output dir_p1, dir_p2, turn_p1, turn_p2, step, paused, qcnt_p1, qcnt_p2, drop
    );
endinterface

// File: rtl/ps2_turn_scheduler.sv
// ps2_turn_scheduler: filters PS/2 key events into queued, legal per-player turns released on game ticks
//   CLOCK_50 : system clock
//   reset    : asynchronous active-high reset
//   bus      : slave side of ps2_turn_scheduler_if (key events, tick/start in; dirs, strobes, counts out)
module ps2_turn_scheduler #(
    parameter int         QDEPTH      = 2,
    parameter logic [1:0] P1_INIT_DIR = 2'd1,
    parameter logic [1:0] P2_INIT_DIR = 2'd3
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    ps2_turn_scheduler_if.slave   bus
);
    logic [1:0][3:0][1:0] q, nq;
    logic [1:0][2:0]      cnt, ncnt;
    logic [1:0][1:0]      dir, ndir;
    logic [1:0]           turn, nturn;
    logic [8:0]           held, nheld;
    logic                 paused, npaused, step, nstep, drop, ndrop;
    logic                 hit, pk, pl;
    logic [1:0]           d, rd, tail;
    logic [3:0]           idx;

    // key map: held-bit index, owning player, direction, pause flag
    always_comb begin
        hit = 1'b1;
        pk  = 1'b0;
        pl  = 1'b0;
        d   = 2'd0;
        idx = 4'd0;
        case (bus.outCode)
            8'h1D: begin idx = 4'd0; d = 2'd0; end
            8'h23: begin idx = 4'd1; d = 2'd1; end
            8'h1B: begin idx = 4'd2; d = 2'd2; end
            8'h1C: begin idx = 4'd3; d = 2'd3; end
            8'h43: begin idx = 4'd4; d = 2'd0; pl = 1'b1; end
            8'h4B: begin idx = 4'd5; d = 2'd1; pl = 1'b1; end
            8'h42: begin idx = 4'd6; d = 2'd2; pl = 1'b1; end
            8'h3B: begin idx = 4'd7; d = 2'd3; pl = 1'b1; end
            8'h4D: begin idx = 4'd8; pk = 1'b1; end
            default: hit = 1'b0;
        endcase
    end

    always_comb begin
        nq      = q;
        ncnt    = cnt;
        ndir    = dir;
        nturn   = 2'b00;
        nstep   = 1'b0;
        ndrop   = 1'b0;
        npaused = paused;
        nheld   = held;
        rd      = 2'd0;
        tail    = 2'd0;
        if (bus.start) begin
            ndir[0] = P1_INIT_DIR;
            ndir[1] = P2_INIT_DIR;
            ncnt    = '0;
            npaused = 1'b0;
        end else begin
            // pop happens first so a same-cycle push sees the post-pop tail
            if (bus.tick && !paused) begin
                nstep = 1'b1;
                for (int p = 0; p < 2; p++) begin
                    if (cnt[p] != 3'd0) begin
                        ndir[p]  = q[p][0];
                        nturn[p] = q[p][0] != dir[p];
                        for (int i = 0; i < 3; i++) nq[p][i] = q[p][i+1];
                        ncnt[p]  = cnt[p] - 3'd1;
                    end
                end
            end
            if (bus.valid && hit) begin
                nheld[idx] = bus.makeBreak;
                // a make on an already-held key is a typematic repeat
                if (bus.makeBreak && !held[idx]) begin
                    if (pk) npaused = !paused;
                    else begin
                        tail = ncnt[pl][1:0] - 2'd1;
                        rd   = ncnt[pl] != 3'd0 ? nq[pl][tail] : ndir[pl];
                        if (d == rd || (d ^ rd) == 2'd2 || ncnt[pl] == 3'(QDEPTH) || paused)
                            ndrop = 1'b1;
                        else begin
                            nq[pl][ncnt[pl][1:0]] = d;
                            ncnt[pl] = ncnt[pl] + 3'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            q      <= '0;
            cnt    <= '0;
            dir    <= {P2_INIT_DIR, P1_INIT_DIR};
            turn   <= 2'b00;
            held   <= 9'd0;
            paused <= 1'b0;
            step   <= 1'b0;
            drop   <= 1'b0;
        end else begin
            q      <= nq;
            cnt    <= ncnt;
            dir    <= ndir;
            turn   <= nturn;
            held   <= nheld;
            paused <= npaused;
            step   <= nstep;
            drop   <= ndrop;
        end
    end

    assign bus.dir_p1  = dir[0];
    assign bus.dir_p2  = dir[1];
    assign bus.turn_p1 = turn[0];
    assign bus.turn_p2 = turn[1];
    assign bus.qcnt_p1 = cnt[0];
    assign bus.qcnt_p2 = cnt[1];
    assign bus.step    = step;
    assign bus.paused  = paused;
    assign bus.drop    = drop;
endmodule

// File: tb/tb_ps2_turn_scheduler.sv
// tb_ps2_turn_scheduler: directed self-checking bench for ps2_turn_scheduler (QDEPTH=2, P1 right, P2 left)
module tb_ps2_turn_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    ps2_turn_scheduler_if bus();
    ps2_turn_scheduler dut (.CLOCK_50(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // apply one cycle of stimulus at a negedge; return at the next negedge with inputs cleared
    task automatic cyc(input logic v, input logic mb, input logic [7:0] code, input logic t, input logic s);
        bus.valid = v; bus.makeBreak = mb; bus.outCode = code; bus.tick = t; bus.start = s;
        @(negedge clk);
        bus.valid = 1'b0; bus.makeBreak = 1'b0; bus.outCode = 8'h00; bus.tick = 1'b0; bus.start = 1'b0;
    endtask

    task automatic test_reset;
        bus.valid = 1'b0; bus.makeBreak = 1'b0; bus.outCode = 8'h00; bus.tick = 1'b0; bus.start = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.dir_p1 !== 2'd1) begin errors++; $display("FAIL rst_dir_p1 got %0d want 1", bus.dir_p1); end
        checks++; if (bus.dir_p2 !== 2'd3) begin errors++; $display("FAIL rst_dir_p2 got %0d want 3", bus.dir_p2); end
        checks++; if (bus.qcnt_p1 !== 3'd0 || bus.qcnt_p2 !== 3'd0) begin errors++; $display("FAIL rst_qcnt got %0d/%0d want 0/0", bus.qcnt_p1, bus.qcnt_p2); end
        checks++; if ({bus.paused, bus.step, bus.turn_p1, bus.turn_p2, bus.drop} !== 5'b0) begin errors++; $display("FAIL rst_flags got %b want 00000", {bus.paused, bus.step, bus.turn_p1, bus.turn_p2, bus.drop}); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_tick_turn;
        cyc(1, 1, 8'h1D, 0, 0);
        checks++; if (bus.qcnt_p1 !== 3'd1 || bus.drop !== 1'b0) begin errors++; $display("FAIL push_up qcnt=%0d drop=%0d want 1/0", bus.qcnt_p1, bus.drop); end
        cyc(1, 0, 8'h1D, 0, 0);
        cyc(0, 0, 8'h00, 1, 0);
        checks++; if (bus.dir_p1 !== 2'd0 || bus.turn_p1 !== 1'b1 || bus.step !== 1'b1) begin errors++; $display("FAIL tick_pop dir=%0d turn=%0d step=%0d want 0/1/1", bus.dir_p1, bus.turn_p1, bus.step); end
        checks++; if (bus.qcnt_p1 !== 3'd0 || bus.turn_p2 !== 1'b0 || bus.dir_p2 !== 2'd3) begin errors++; $display("FAIL tick_other qcnt1=%0d turn2=%0d dir2=%0d want 0/0/3", bus.qcnt_p1, bus.turn_p2, bus.dir_p2); end
        cyc(0, 0, 8'h00, 0, 0);
        checks++; if (bus.step !== 1'b0 || bus.turn_p1 !== 1'b0) begin errors++; $display("FAIL pulse_len step=%0d turn=%0d want 0/0", bus.step, bus.turn_p1); end
        cyc(0, 0, 8'h00, 0, 1);
        checks++; if (bus.dir_p1 !== 2'd1 || bus.step !== 1'b0) begin errors++; $display("FAIL start_dir dir=%0d step=%0d want 1/0", bus.dir_p1, bus.step); end
    endtask

    task automatic test_illegal;
        cyc(1, 1, 8'h1C, 0, 0);
        checks++; if (bus.drop !== 1'b1 || bus.qcnt_p1 !== 3'd0) begin errors++; $display("FAIL reverse_dir drop=%0d qcnt=%0d want 1/0", bus.drop, bus.qcnt_p1); end
        cyc(1, 0, 8'h1C, 0, 0);
        checks++; if (bus.drop !== 1'b0) begin errors++; $display("FAIL break_nodrop drop=%0d want 0", bus.drop); end
        cyc(1, 1, 8'h23, 0, 0);
        checks++; if (bus.drop !== 1'b1 || bus.qcnt_p1 !== 3'd0) begin errors++; $display("FAIL same_dir drop=%0d qcnt=%0d want 1/0", bus.drop, bus.qcnt_p1); end
        cyc(1, 0, 8'h23, 0, 0);
        cyc(1, 1, 8'h1D, 0, 0);
        cyc(1, 0, 8'h1D, 0, 0);
        cyc(1, 1, 8'h1B, 0, 0);
        checks++; if (bus.drop !== 1'b1 || bus.qcnt_p1 !== 3'd1) begin errors++; $display("FAIL reverse_tail drop=%0d qcnt=%0d want 1/1", bus.drop, bus.qcnt_p1); end
        cyc(1, 0, 8'h1B, 0, 0);
        cyc(1, 1, 8'h5A, 0, 0);
        checks++; if (bus.drop !== 1'b0 || bus.qcnt_p1 !== 3'd1) begin errors++; $display("FAIL unmapped drop=%0d qcnt=%0d want 0/1", bus.drop, bus.qcnt_p1); end
        cyc(0, 0, 8'h00, 0, 1);
        checks++; if (bus.qcnt_p1 !== 3'd0 || bus.dir_p1 !== 2'd1) begin errors++; $display("FAIL start_flush qcnt=%0d dir=%0d want 0/1", bus.qcnt_p1, bus.dir_p1); end
    endtask

    task automatic test_typematic;
        cyc(1, 1, 8'h43, 0, 0);
        checks++; if (bus.qcnt_p2 !== 3'd1 || bus.drop !== 1'b0) begin errors++; $display("FAIL p2_push qcnt=%0d drop=%0d want 1/0", bus.qcnt_p2, bus.drop); end
        cyc(1, 1, 8'h43, 0, 0);
        cyc(1, 1, 8'h43, 0, 0);
        checks++; if (bus.qcnt_p2 !== 3'd1 || bus.drop !== 1'b0) begin errors++; $display("FAIL typematic qcnt=%0d drop=%0d want 1/0", bus.qcnt_p2, bus.drop); end
        cyc(1, 0, 8'h43, 0, 0);
        cyc(1, 1, 8'h43, 0, 0);
        checks++; if (bus.qcnt_p2 !== 3'd1 || bus.drop !== 1'b1) begin errors++; $display("FAIL repress_same qcnt=%0d drop=%0d want 1/1", bus.qcnt_p2, bus.drop); end
        cyc(1, 0, 8'h43, 0, 0);
    endtask

    task automatic test_full;
        cyc(1, 1, 8'h3B, 0, 0);
        checks++; if (bus.qcnt_p2 !== 3'd2 || bus.drop !== 1'b0) begin errors++; $display("FAIL second_push qcnt=%0d drop=%0d want 2/0", bus.qcnt_p2, bus.drop); end
        cyc(1, 0, 8'h3B, 0, 0);
        cyc(1, 1, 8'h42, 0, 0);
        checks++; if (bus.qcnt_p2 !== 3'd2 || bus.drop !== 1'b1) begin errors++; $display("FAIL full_drop qcnt=%0d drop=%0d want 2/1", bus.qcnt_p2, bus.drop); end
        cyc(1, 0, 8'h42, 0, 0);
        cyc(1, 1, 8'h42, 1, 0);
        checks++; if (bus.qcnt_p2 !== 3'd2 || bus.drop !== 1'b0) begin errors++; $display("FAIL full_tick_push qcnt=%0d drop=%0d want 2/0", bus.qcnt_p2, bus.drop); end
        checks++; if (bus.dir_p2 !== 2'd0 || bus.turn_p2 !== 1'b1 || bus.turn_p1 !== 1'b0) begin errors++; $display("FAIL full_tick_pop dir=%0d turn2=%0d turn1=%0d want 0/1/0", bus.dir_p2, bus.turn_p2, bus.turn_p1); end
        cyc(1, 0, 8'h42, 0, 0);
    endtask

    task automatic test_pause;
        cyc(1, 1, 8'h4D, 0, 0);
        checks++; if (bus.paused !== 1'b1) begin errors++; $display("FAIL pause_on got %0d want 1", bus.paused); end
        cyc(1, 0, 8'h4D, 0, 0);
        cyc(0, 0, 8'h00, 1, 0);
        checks++; if (bus.step !== 1'b0 || bus.dir_p2 !== 2'd0 || bus.qcnt_p2 !== 3'd2 || bus.turn_p2 !== 1'b0) begin errors++; $display("FAIL paused_tick step=%0d dir=%0d qcnt=%0d turn=%0d want 0/0/2/0", bus.step, bus.dir_p2, bus.qcnt_p2, bus.turn_p2); end
        cyc(1, 1, 8'h1D, 0, 0);
        checks++; if (bus.drop !== 1'b1 || bus.qcnt_p1 !== 3'd0) begin errors++; $display("FAIL paused_push drop=%0d qcnt=%0d want 1/0", bus.drop, bus.qcnt_p1); end
        cyc(1, 0, 8'h1D, 0, 0);
        cyc(1, 1, 8'h4D, 0, 0);
        checks++; if (bus.paused !== 1'b0) begin errors++; $display("FAIL pause_off got %0d want 0", bus.paused); end
        cyc(1, 0, 8'h4D, 0, 0);
        cyc(0, 0, 8'h00, 1, 0);
        checks++; if (bus.step !== 1'b1 || bus.dir_p2 !== 2'd3 || bus.qcnt_p2 !== 3'd1 || bus.turn_p2 !== 1'b1) begin errors++; $display("FAIL resumed_tick step=%0d dir=%0d qcnt=%0d turn=%0d want 1/3/1/1", bus.step, bus.dir_p2, bus.qcnt_p2, bus.turn_p2); end
        cyc(1, 1, 8'h4D, 1, 0);
        checks++; if (bus.step !== 1'b1 || bus.paused !== 1'b1 || bus.dir_p2 !== 2'd2 || bus.qcnt_p2 !== 3'd0) begin errors++; $display("FAIL tick_with_pause step=%0d paused=%0d dir=%0d qcnt=%0d want 1/1/2/0", bus.step, bus.paused, bus.dir_p2, bus.qcnt_p2); end
        cyc(1, 0, 8'h4D, 0, 0);
        cyc(1, 1, 8'h4D, 0, 0);
        cyc(1, 0, 8'h4D, 0, 0);
    endtask

    task automatic test_reset_mid;
        cyc(1, 1, 8'h1D, 0, 0);
        checks++; if (bus.qcnt_p1 !== 3'd1 || bus.paused !== 1'b0) begin errors++; $display("FAIL pre_reset qcnt=%0d paused=%0d want 1/0", bus.qcnt_p1, bus.paused); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.qcnt_p1 !== 3'd0 || bus.dir_p2 !== 2'd3) begin errors++; $display("FAIL async_reset qcnt=%0d dir2=%0d want 0/3", bus.qcnt_p1, bus.dir_p2); end
        @(negedge clk);
        reset = 1'b0;
        cyc(1, 1, 8'h1D, 0, 0);
        checks++; if (bus.qcnt_p1 !== 3'd1 || bus.drop !== 1'b0) begin errors++; $display("FAIL post_reset qcnt=%0d drop=%0d want 1/0", bus.qcnt_p1, bus.drop); end
    endtask

    initial begin
        test_reset;
        test_tick_turn;
        test_illegal;
        test_typematic;
        test_full;
        test_pause;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_turn_scheduler.md
# ps2_turn_scheduler

Sequences decoded PS/2 key events into per-player steering commands for the two-player light-cycle game. Sits between `keyboard_press_driver` (valid/makeBreak/outCode) and the game-step logic. Filters typematic repeats, rejects illegal turns, buffers up to QDEPTH turns per player, and releases one turn per player on each unpaused game tick.

## Interface
- QDEPTH, 2, per-player turn queue depth (1..4)
- P1_INIT_DIR, 2'd1, player-1 direction after reset/start (0 up, 1 right, 2 down, 3 left)
- P2_INIT_DIR, 2'd3, player-2 direction after reset/start
- CLOCK_50  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high; forces reset state immediately
- valid  in  1  one-cycle strobe: outCode/makeBreak carry a key event
- makeBreak  in  1  1 = make (press), 0 = break (release)
- outCode  in  8  set-2 scan code of the event
- tick  in  1  one-cycle game-step strobe
- start  in  1  one-cycle synchronous re-initialise strobe
- dir_p1, dir_p2  out  2  current committed directions
- turn_p1, turn_p2  out  1  one-cycle strobe: direction changed this step
- step  out  1  one-cycle strobe: tick accepted (not paused)
- paused  out  1  pause state
- qcnt_p1, qcnt_p2  out  3  queue occupancy
- drop  out  1  one-cycle strobe: a legal-key make was discarded

## Operation
- Key map (non-extended codes only): P1 W=8'h1D up, D=8'h23 right, S=8'h1B down, A=8'h1C left; P2 I=8'h43 up, L=8'h4B right, K=8'h42 down, J=8'h3B left; P=8'h4D pause toggle. All other codes ignored, no drop.
- Held-key filter: one held bit per mapped key (9 bits). Make with held=0 → act and set held. Make with held=1 → ignore silently (typematic). Break → clear held, no other action.
- Push candidate d for player p: reference r = tail entry of queue p if qcnt>0, else dir_p. Reject (drop=1) if d==r, (d^r)==2 (reversal), queue full (after any same-cycle pop), or paused. Otherwise append.
- Pause key make: toggle paused. Queues and dirs frozen while paused.
- tick with paused=0: step=1; for each player with qcnt>0, pop head into dir_p, turn_p=1 if value differs from old dir_p (always true by construction). tick with paused=1: no effect, step=0.
- start: dirs ← init values, queues emptied, paused ← 0, held bits kept; takes priority over tick and key event in the same cycle; no strobes.
- reset: dirs ← P1_INIT_DIR/P2_INIT_DIR, queues empty, held all 0, paused 0, all strobes 0, qcnt 0.

## Timing
- All outputs registered. Key event at edge N → qcnt/drop/paused visible after edge N (cycle N+1). tick at edge N → dir/turn/step visible after edge N.
- turn, step, drop are single-cycle pulses; never held.
- Simultaneous tick and push for same player: pop first, then push compared against post-pop reference (new tail, or popped value if queue became empty); full queue plus tick accepts the push, qcnt unchanged.
- Simultaneous tick and pause toggle: tick evaluated with pre-toggle paused.
- Only one key event per cycle (valid is a strobe); at most one push per cycle total.
- Reset asserted mid-operation: outputs return to reset values asynchronously; first event after deassertion processed normally.

## Test plan
- Reset → dir_p1=1, dir_p2=3, qcnt=0, paused=0, strobes 0.
- P1 make 1D, tick → qcnt_p1 1 then 0, dir_p1=0, turn_p1=1, step=1 same cycle.
- P1 dir right: make 1C (left) → drop=1, qcnt_p1=0; make 1D, break 1D, make 1B (down after queued up) → second drops as reversal.
- Typematic: make 43 three times without break → one push only, no drop; break 43, make 43 → dropped as same-direction (qcnt 1).
- QDEPTH=2: P2 pushes 43, 3B, 42 → third drop=1, qcnt_p2=2; push 42 in cycle with tick → accepted, qcnt stays 2.
- Make 4D, tick → step=0, dirs unchanged; make 4D again, tick → step=1; assert reset mid-queue → qcnt 0 immediately.
